// File: rtl/ram_dp_sync.sv
// rtl/ram_dp_sync.sv - dual-port synchronous RAM: data port with byte enables, read-only fetch port, clear sweep
module ram_dp_sync #(
  parameter int DW             = 32,
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            enable_i,
  input  logic [1:0]      rw_i,
  input  logic [31:0]     addr_i,
  input  logic [DW-1:0]   din_i,
  input  logic [DW/8-1:0] be_i,
  output logic [DW-1:0]   dout_o,
  output logic            dvalid_o,
  input  logic            fen_i,
  input  logic [31:0]     faddr_i,
  output logic [DW-1:0]   fetch_o,
  output logic            fvalid_o,
  output logic            err_o,
  output logic            busy_o
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          NB      = DW / 8;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dout_q, fetch_q;
  logic          dvalid_q, fvalid_q, err_q;
  logic [DW-1:0] mem [DEPTH];

  logic ready, d_in, f_in, d_rd, d_wr, d_clr, f_rd, any_oor;

  // Full 32-bit compares so high address bits can never alias into the array.
  always_comb begin
    ready   = (state_q == S_READY);
    d_in    = (addr_i < DEPTH_U);
    f_in    = (faddr_i < DEPTH_U);
    d_rd    = ready && enable_i && (rw_i == 2'b01) && d_in;
    d_wr    = ready && enable_i && (rw_i == 2'b10) && d_in;
    d_clr   = ready && enable_i && (rw_i == 2'b11);
    f_rd    = ready && fen_i && f_in;
    any_oor = ready && ((enable_i && (rw_i == 2'b01 || rw_i == 2'b10) && !d_in) ||
                        (fen_i && !f_in));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_READY;
          cnt_d   = '0;
        end
      end
      S_READY: begin
        if (d_clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      dout_q   <= '0;
      fetch_q  <= '0;
      dvalid_q <= 1'b0;
      fvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvalid_q <= d_rd;
      fvalid_q <= f_rd;
      err_q    <= any_oor;
      if (d_rd) dout_q  <= mem[addr_i[AW-1:0]];
      if (f_rd) fetch_q <= mem[faddr_i[AW-1:0]];
    end
  end

  // Array has no reset; fetch samples the pre-write word on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (state_q == S_CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (d_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem[addr_i[AW-1:0]][8*b +: 8] <= din_i[8*b +: 8];
      end
    end
  end

  assign dout_o   = dout_q;
  assign fetch_o  = fetch_q;
  assign dvalid_o = dvalid_q;
  assign fvalid_o = fvalid_q;
  assign err_o    = err_q;
  assign busy_o   = (state_q == S_CLEAR);

endmodule
